// File: rtl/gpu_tex_pkg.sv
// Shared texture-format codes, fetch FSM states and the palette index helper
// for the texel-fetch pipeline.
package gpu_tex_pkg;

    localparam logic [1:0]  FMT_4BPP    = 2'd0;
    localparam logic [1:0]  FMT_8BPP    = 2'd1;
    localparam logic [1:0]  FMT_15BPP   = 2'd2;
    localparam logic [15:0] WHITE_TEXEL = 16'h7FFF;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_TFILL,
        ST_TREPLAY,
        ST_CFILL,
        ST_CREPLAY
    } fetchState_t;

    // Palette index out of a 16-bit texel word: nibble by uLsb for 4bpp, byte by uLsb[0] for 8bpp.
    function automatic logic [7:0] texIndex(input logic [1:0]  fmt,
                                            input logic [15:0] data,
                                            input logic [1:0]  uLsb);
        logic [7:0] idx;
        idx = uLsb[0] ? data[15:8] : data[7:0];
        if (fmt == FMT_4BPP) begin
            case (uLsb)
                2'd0:    idx = {4'h0, data[3:0]};
                2'd1:    idx = {4'h0, data[7:4]};
                2'd2:    idx = {4'h0, data[11:8]};
                default: idx = {4'h0, data[15:12]};
            endcase
        end
        return idx;
    endfunction

endpackage

// File: rtl/gpu_pix_fifo.sv
// Synchronous FIFO with occupancy count; the head word reads as zero while empty.
module gpu_pix_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_nrst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPop;

    assign o_valid = (o_count != '0);
    assign doPop   = i_pop & o_valid;
    assign o_data  = o_valid ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            mem[wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({i_push, doPop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_tex_fetch_pipe.sv
// Texel-fetch pipeline: c0 accept / Tex$ lookup, c1 Tex$ response + Clut$ lookup,
// c2 colour select into an output FIFO; owns the cache-miss fill/replay FSM.
module gpu_tex_fetch_pipe
    import gpu_tex_pkg::*;
#(
    parameter int SCRX_W    = 10,
    parameter int SCRY_W    = 9,
    parameter int COL_W     = 9,
    parameter int TADR_W    = 19,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic [1:0]        GPU_REG_TexFormat,
    input  logic [14:0]       GPU_REG_CLUT,
    input  logic              GPU_TEX_DISABLE,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [SCRX_W-1:0] i_scrX,
    input  logic [SCRY_W-1:0] i_scrY,
    input  logic [COL_W-1:0]  i_R,
    input  logic [COL_W-1:0]  i_G,
    input  logic [COL_W-1:0]  i_B,
    input  logic [1:0]        i_uLSB,
    input  logic [TADR_W-1:0] i_texAdr,
    output logic              o_requTex,
    output logic [TADR_W-1:0] o_adrTex,
    input  logic              i_texHit,
    input  logic              i_texMiss,
    input  logic [15:0]       i_texData,
    output logic              o_requTexFill,
    output logic [TADR_W-3:0] o_adrTexFill,
    input  logic              i_texFillDone,
    output logic              o_requClut,
    output logic [7:0]        o_clutIndex,
    input  logic              i_clutHit,
    input  logic              i_clutMiss,
    input  logic [15:0]       i_clutData,
    output logic              o_requClutFill,
    output logic [14:0]       o_adrClutFill,
    input  logic              i_clutFillDone,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [SCRX_W-1:0] o_scrX,
    output logic [SCRY_W-1:0] o_scrY,
    output logic [COL_W-1:0]  o_R,
    output logic [COL_W-1:0]  o_G,
    output logic [COL_W-1:0]  o_B,
    output logic [15:0]       o_texel,
    output logic              o_transparent
);
    localparam int PIX_W  = SCRX_W + SCRY_W + 3 * COL_W;
    localparam int FIFO_W = PIX_W + 17;
    localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(OUT_DEPTH);

    fetchState_t       stateReg;
    logic              c1Valid, c1TexDis;
    logic [PIX_W-1:0]  c1Pix;
    logic [1:0]        c1Fmt, c1ULsb;
    logic [TADR_W-1:0] c1Adr;
    logic              c2Valid, c2Textured, c2UsePal;
    logic [PIX_W-1:0]  c2Pix;
    logic [15:0]       c2Texel;
    logic [7:0]        clutIdxReg;

    logic              isRun, isCReplay;
    logic              c1Textured, c1Pal;
    logic [7:0]        c1Index;
    logic              texMissNow, clutMissRun, clutMissReplay, advance, accept;
    logic [CNT_W-1:0]  fifoCount;
    logic [CNT_W:0]    creditSum;
    logic [15:0]       c2Colour;
    logic              c2Transp;
    logic [FIFO_W-1:0] fifoHead;

    assign isRun      = (stateReg == ST_RUN);
    assign isCReplay  = (stateReg == ST_CREPLAY);
    assign c1Textured = c1Valid & ~c1TexDis;
    assign c1Pal      = (c1Fmt == FMT_4BPP) | (c1Fmt == FMT_8BPP);
    assign c1Index    = texIndex(c1Fmt, i_texData, c1ULsb);

    assign texMissNow     = isRun & c1Textured & i_texMiss;
    assign clutMissRun    = isRun & c1Textured & c1Pal & ~i_texMiss & i_clutMiss;
    assign clutMissReplay = isCReplay & i_clutMiss;
    assign advance        = (isRun & ~texMissNow & ~clutMissRun) | (isCReplay & i_clutHit);

    // Input is also refused in the cycle a miss freezes c1, since there is nowhere to park it.
    assign creditSum = {1'b0, fifoCount} + (CNT_W+1)'(c1Valid) + (CNT_W+1)'(c2Valid);
    assign o_ready   = isRun & ~texMissNow & ~clutMissRun & (creditSum < DEPTH_L);
    assign accept    = i_valid & o_ready;

    assign o_requTex     = (accept & ~GPU_TEX_DISABLE) | (stateReg == ST_TREPLAY);
    assign o_adrTex      = (stateReg == ST_TREPLAY) ? c1Adr : i_texAdr;
    assign o_requTexFill = texMissNow;
    assign o_adrTexFill  = c1Adr[TADR_W-1:2];

    assign o_clutIndex    = isCReplay ? clutIdxReg : c1Index;
    assign o_requClut     = (isRun & c1Textured & c1Pal & i_texHit) | isCReplay;
    assign o_requClutFill = clutMissRun | clutMissReplay;
    assign o_adrClutFill  = {GPU_REG_CLUT[14:6], GPU_REG_CLUT[5:0] + {2'b00, o_clutIndex[7:4]}};

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stateReg   <= ST_RUN;
            clutIdxReg <= '0;
        end else begin
            case (stateReg)
                ST_RUN: begin
                    if (texMissNow) begin
                        stateReg <= ST_TFILL;
                    end else if (clutMissRun) begin
                        stateReg   <= ST_CFILL;
                        clutIdxReg <= c1Index;
                    end
                end
                ST_TFILL:   if (i_texFillDone)  stateReg <= ST_TREPLAY;
                ST_TREPLAY: stateReg <= ST_RUN;
                ST_CFILL:   if (i_clutFillDone) stateReg <= ST_CREPLAY;
                ST_CREPLAY: begin
                    if (i_clutHit)       stateReg <= ST_RUN;
                    else if (i_clutMiss) stateReg <= ST_CFILL;
                end
                default:    stateReg <= ST_RUN;
            endcase
        end
    end

    // c2 always drains into the FIFO (credit guarantees room), so a frozen c1 leaves a bubble behind it.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            c1Valid    <= 1'b0;
            c1TexDis   <= 1'b0;
            c1Pix      <= '0;
            c1Fmt      <= '0;
            c1ULsb     <= '0;
            c1Adr      <= '0;
            c2Valid    <= 1'b0;
            c2Textured <= 1'b0;
            c2UsePal   <= 1'b0;
            c2Pix      <= '0;
            c2Texel    <= '0;
        end else if (advance) begin
            c1Valid    <= accept;
            c1TexDis   <= GPU_TEX_DISABLE;
            c1Pix      <= {i_scrX, i_scrY, i_R, i_G, i_B};
            c1Fmt      <= GPU_REG_TexFormat;
            c1ULsb     <= i_uLSB;
            c1Adr      <= i_texAdr;
            c2Valid    <= c1Valid;
            c2Textured <= ~c1TexDis;
            c2UsePal   <= ~c1TexDis & c1Pal;
            c2Pix      <= c1Pix;
            c2Texel    <= c1TexDis ? WHITE_TEXEL : i_texData;
        end else begin
            c2Valid <= 1'b0;
        end
    end

    assign c2Colour = c2UsePal ? i_clutData : c2Texel;
    assign c2Transp = c2Textured & (c2Colour[14:0] == 15'd0);

    gpu_pix_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (OUT_DEPTH)
    ) u_outFifo (
        .clk     (clk),
        .i_nrst  (i_nrst),
        .i_push  (c2Valid),
        .i_data  ({c2Pix, c2Colour, c2Transp}),
        .i_pop   (i_ready),
        .o_data  (fifoHead),
        .o_count (fifoCount),
        .o_valid (o_valid)
    );

    assign {o_scrX, o_scrY, o_R, o_G, o_B, o_texel, o_transparent} = fifoHead;

endmodule

// File: tb/tb_gpu_tex_fetch_pipe.sv
// Scoreboard bench for gpu_tex_fetch_pipe with behavioural Tex$/Clut$ models
// that can inject misses and answer fill requests.
module tb_gpu_tex_fetch_pipe;
    import gpu_tex_pkg::*;

    localparam int OUT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic [1:0]  GPU_REG_TexFormat;
    logic [14:0] GPU_REG_CLUT;
    logic        GPU_TEX_DISABLE;
    logic        i_valid;
    logic        o_ready;
    logic [9:0]  i_scrX;
    logic [8:0]  i_scrY, i_R, i_G, i_B;
    logic [1:0]  i_uLSB;
    logic [18:0] i_texAdr;
    logic        o_requTex;
    logic [18:0] o_adrTex;
    logic        i_texHit = 1'b0, i_texMiss = 1'b0;
    logic [15:0] i_texData = 16'h0;
    logic        o_requTexFill;
    logic [16:0] o_adrTexFill;
    logic        i_texFillDone = 1'b0;
    logic        o_requClut;
    logic [7:0]  o_clutIndex;
    logic        i_clutHit, i_clutMiss;
    logic [15:0] i_clutData = 16'h0;
    logic        o_requClutFill;
    logic [14:0] o_adrClutFill;
    logic        i_clutFillDone = 1'b0;
    logic        o_valid;
    logic        i_ready;
    logic [9:0]  o_scrX;
    logic [8:0]  o_scrY, o_R, o_G, o_B;
    logic [15:0] o_texel;
    logic        o_transparent;

    gpu_tex_fetch_pipe #(.OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .i_nrst(i_nrst),
        .GPU_REG_TexFormat(GPU_REG_TexFormat), .GPU_REG_CLUT(GPU_REG_CLUT),
        .GPU_TEX_DISABLE(GPU_TEX_DISABLE),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_scrX(i_scrX), .i_scrY(i_scrY), .i_R(i_R), .i_G(i_G), .i_B(i_B),
        .i_uLSB(i_uLSB), .i_texAdr(i_texAdr),
        .o_requTex(o_requTex), .o_adrTex(o_adrTex),
        .i_texHit(i_texHit), .i_texMiss(i_texMiss), .i_texData(i_texData),
        .o_requTexFill(o_requTexFill), .o_adrTexFill(o_adrTexFill), .i_texFillDone(i_texFillDone),
        .o_requClut(o_requClut), .o_clutIndex(o_clutIndex),
        .i_clutHit(i_clutHit), .i_clutMiss(i_clutMiss), .i_clutData(i_clutData),
        .o_requClutFill(o_requClutFill), .o_adrClutFill(o_adrClutFill), .i_clutFillDone(i_clutFillDone),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_scrX(o_scrX), .o_scrY(o_scrY), .o_R(o_R), .o_G(o_G), .o_B(o_B),
        .o_texel(o_texel), .o_transparent(o_transparent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y, r, g, b;
        logic [15:0] texel;
        logic        transp;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t outE;
    int   nChecks = 0, nFails = 0;
    int   cyc = 0, acceptCnt = 0, outCnt = 0;
    bit   latChk = 0;

    // Cache model state
    logic [15:0] clutMem [256];
    int          texArmCnt = 0, texFillCnt = 0, texTimer = 0, texReqMissCnt = 0;
    int          clutArmCnt = 0, clutFillCnt = 0, clutTimer = 0;
    logic [18:0] texMissAdr = 19'h7FFFF;
    logic [16:0] lastTexFillAdr = '0;
    logic [14:0] lastClutFillAdr = '0;
    logic [7:0]  lastClutIdx = '0;
    logic        sReqTex, sReqClut, sTFill, sCFill, texMissing;
    logic [18:0] sAdrTex;
    logic [7:0]  sIdx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        nChecks++;
        if (got !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Tex$: response one cycle after the request; Clut$: data one cycle after the lookup.
    always @(posedge clk) begin
        sReqTex  = o_requTex;
        sAdrTex  = o_adrTex;
        sReqClut = o_requClut;
        sIdx     = o_clutIndex;
        sTFill   = o_requTexFill;
        sCFill   = o_requClutFill;
        if (sReqClut) lastClutIdx = sIdx;
        if (sReqTex && sAdrTex == texMissAdr) texReqMissCnt++;
        if (sTFill) lastTexFillAdr = o_adrTexFill;
        if (sCFill) lastClutFillAdr = o_adrClutFill;
        #1;
        texMissing = (texArmCnt > texFillCnt) && (sAdrTex == texMissAdr);
        i_texHit   = sReqTex && !texMissing;
        i_texMiss  = sReqTex && texMissing;
        i_texData  = sReqTex ? sAdrTex[15:0] : 16'h0;
        i_clutData = clutMem[sIdx];
        i_texFillDone  = (texTimer == 1);
        i_clutFillDone = (clutTimer == 1);
        if (texTimer > 0)  texTimer--;
        if (clutTimer > 0) clutTimer--;
        if (sTFill) begin texFillCnt++;  texTimer  = 10; end
        if (sCFill) begin clutFillCnt++; clutTimer = 4;  end
    end

    always @* begin
        i_clutMiss = o_requClut && (clutArmCnt > clutFillCnt);
        i_clutHit  = o_requClut && !(clutArmCnt > clutFillCnt);
    end

    function automatic logic [15:0] refColour(input logic [18:0] adr, input logic [1:0] u,
                                              input logic [1:0] fmt, input logic dis);
        logic [15:0] w;
        logic [7:0]  idx;
        if (dis) return 16'h7FFF;
        w = adr[15:0];
        if (fmt == FMT_15BPP) return w;
        if (fmt == FMT_4BPP) idx = 8'((w >> (4 * u)) & 16'h000F);
        else                 idx = 8'(w >> (8 * u[0]));
        return clutMem[idx];
    endfunction

    task automatic sendPix(input int x, input logic [1:0] u, input logic [18:0] adr, output int waits);
        exp_t e;
        waits    = 0;
        i_valid  = 1'b1;
        i_scrX   = 10'(x);
        i_scrY   = 9'(x * 3);
        i_R      = 9'(x + 1);
        i_G      = 9'(x + 2);
        i_B      = 9'(x ^ 85);
        i_uLSB   = u;
        i_texAdr = adr;
        forever begin
            @(negedge clk);
            if (o_ready) begin
                e.x = i_scrX; e.y = i_scrY; e.r = i_R; e.g = i_G; e.b = i_B;
                e.texel  = refColour(adr, u, GPU_REG_TexFormat, GPU_TEX_DISABLE);
                e.transp = !GPU_TEX_DISABLE && (e.texel[14:0] == 15'd0);
                e.cyc    = cyc;
                sbq.push_back(e);
                acceptCnt++;
                break;
            end
            waits++;
            if (waits > 300) begin
                check("accept_timeout", 64'(waits), 0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(sbq.size()), 0);
    endtask

    always @(negedge clk) begin
        if (i_nrst && o_valid && i_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                outE = sbq.pop_front();
                check("scr", {o_scrX, o_scrY}, {outE.x, outE.y});
                check("rgb", {o_R, o_G, o_B}, {outE.r, outE.g, outE.b});
                check("texel", o_texel, outE.texel);
                check("transp", o_transparent, outE.transp);
                if (latChk) check("latency", 64'(cyc - outE.cyc), 3);
                outCnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wsum, base, n;
        for (int i = 0; i < 256; i++) clutMem[i] = 16'(i * 257 + 16'h1111);
        clutMem[5] = 16'h8000;
        i_nrst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        GPU_REG_TexFormat = FMT_15BPP; GPU_REG_CLUT = 15'h0; GPU_TEX_DISABLE = 1'b0;
        i_scrX = '0; i_scrY = '0; i_R = '0; i_G = '0; i_B = '0; i_uLSB = '0; i_texAdr = '0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_requTex", o_requTex, 0);
        check("rst_fills", {o_requTexFill, o_requClutFill, o_requClut}, 0);
        check("rst_texel", o_texel, 0);
        repeat (3) @(posedge clk);
        #1 i_nrst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", o_ready, 1);

        // 1: 15bpp, all hits, back-to-back, fixed latency
        latChk = 1; wsum = 0;
        for (int k = 0; k < 8; k++) begin
            sendPix(k, 2'(k), 19'(32'h1000 + k * 37), w);
            wsum += w;
        end
        drain("t1_drain");
        check("t1_ready_stalls", 64'(wsum), 0);
        latChk = 0;

        // 2: 4bpp palette lookups, incl. transparent colour
        GPU_REG_TexFormat = FMT_4BPP;
        sendPix(20, 2'd1, 19'h00A50, w);
        repeat (3) @(posedge clk); #1;
        check("t2_index_u1", lastClutIdx, 8'h05);
        sendPix(21, 2'd2, 19'h00A50, w);
        repeat (3) @(posedge clk); #1;
        check("t2_index_u2", lastClutIdx, 8'h0A);
        drain("t2_drain");

        // 3: Tex$ miss on pixel 3 of 5
        GPU_REG_TexFormat = FMT_15BPP;
        texMissAdr = 19'h0200A; texArmCnt = texFillCnt + 1;
        base = texFillCnt; n = texReqMissCnt;
        for (int k = 0; k < 5; k++) sendPix(30 + k, 2'd0, 19'(32'h2000 + k * 5), w);
        drain("t3_drain");
        check("t3_fill_pulses", 64'(texFillCnt - base), 1);
        check("t3_fill_adr", lastTexFillAdr, 17'h00802);
        check("t3_replay_req", 64'(texReqMissCnt - n), 2);

        // 4: Clut$ miss with wrapped fill address, miss again after replay
        GPU_REG_TexFormat = FMT_8BPP; GPU_REG_CLUT = 15'h0FFE;
        base = clutFillCnt; clutArmCnt = clutFillCnt + 2;
        sendPix(40, 2'd0, 19'h0302F, w);
        drain("t4_drain");
        check("t4_fill_pulses", 64'(clutFillCnt - base), 2);
        check("t4_fill_adr", lastClutFillAdr, 15'h0FC0);
        check("t4_index", lastClutIdx, 8'h2F);

        // 5: downstream stall with continuous input
        i_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) sendPix(50 + k, 2'(k), 19'(32'h4000 + k * 11), w);
            end
            begin
                base = acceptCnt;
                repeat (20) @(posedge clk);
                @(negedge clk);
                check("t5_buffered", 64'(acceptCnt - base), OUT_DEPTH);
                check("t5_ready_low", o_ready, 0);
                check("t5_valid", o_valid, 1);
                @(posedge clk); #1;
                i_ready = 1'b1;
            end
        join
        drain("t5_drain");

        // 6: async reset while a Tex$ fill is outstanding
        GPU_REG_TexFormat = FMT_15BPP;
        i_ready = 1'b0;
        texMissAdr = 19'h00777; texArmCnt = texFillCnt + 1;
        base = texFillCnt;
        sendPix(60, 2'd0, 19'h00100, w);
        sendPix(61, 2'd0, 19'h00777, w);
        n = 0;
        while (texFillCnt == base && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_fill_seen", 64'(texFillCnt - base), 1);
        repeat (3) @(posedge clk); #1;
        check("t6_pre_valid", o_valid, 1);
        i_nrst = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_fill", {o_requTexFill, o_requClutFill}, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 i_nrst = 1'b1;
        @(posedge clk); #1;
        check("t6_ready", o_ready, 1);
        i_ready = 1'b1;
        GPU_TEX_DISABLE = 1'b1;
        repeat (12) @(posedge clk); #1;
        check("t6_idle_valid", o_valid, 0);
        sendPix(62, 2'd0, 19'h00777, w);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
